// File: rtl/ccl_pkg.sv
// rtl/ccl_pkg.sv - shared constants and state type for the connected-component labeler
package ccl_pkg;

  localparam logic [1:0] UF_OP_FIND  = 2'b00;
  localparam logic [1:0] UF_OP_UNION = 2'b01;
  localparam int         LBL_BG      = 0;

  typedef enum logic [1:0] {
    SCAN,
    UF_REQ,
    UF_WAIT
  } scan_state_t;

endpackage

// File: rtl/ccl_line_buffer.sv
// rtl/ccl_line_buffer.sv - one-line label store, shared read/write address, read-before-write
module ccl_line_buffer #(
  parameter int IMG_W      = 640,
  parameter int ADDR_WIDTH = 8,
  parameter int COL_W      = 10
) (
  input  logic                  clk,
  input  logic [COL_W-1:0]      addr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] rdata
);

  logic [ADDR_WIDTH-1:0] mem [IMG_W];

  // Asynchronous read returns the previous line's label before this cycle's write lands.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/ccl_label_scanner.sv
// rtl/ccl_label_scanner.sv - first-pass raster labeler issuing UNION requests to union-find
module ccl_label_scanner
  import ccl_pkg::*;
#(
  parameter int N          = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int COL_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  pix_bin,
  input  logic                  pix_sof,
  input  logic                  pix_eol,
  output logic                  lbl_valid,
  output logic [ADDR_WIDTH-1:0] lbl_label,
  output logic                  lbl_eol,
  output logic                  uf_start,
  output logic [1:0]            uf_op,
  output logic [ADDR_WIDTH-1:0] uf_node1,
  output logic [ADDR_WIDTH-1:0] uf_node2,
  input  logic                  uf_done,
  output logic [ADDR_WIDTH-1:0] label_cnt,
  output logic                  lbl_ovf,
  output logic                  line_err
);

  localparam logic [ADDR_WIDTH-1:0] BG        = ADDR_WIDTH'(LBL_BG);
  localparam logic [ADDR_WIDTH-1:0] LBL_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LBL_MAX   = ADDR_WIDTH'(N - 1);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_W - 1);

  scan_state_t           state, state_n;
  logic [COL_W-1:0]      col, eff_col;
  logic                  first_row, eff_first;
  logic [ADDR_WIDTH-1:0] next_label, eff_next, left_lbl;
  logic [ADDR_WIDTH-1:0] lft, up, cur, buf_rd;
  logic                  accept, is_new, conflict, line_end, bad_end;

  ccl_line_buffer #(
    .IMG_W     (IMG_W),
    .ADDR_WIDTH(ADDR_WIDTH),
    .COL_W     (COL_W)
  ) u_line_buf (
    .clk  (clk),
    .addr (eff_col),
    .we   (accept),
    .wdata(cur),
    .rdata(buf_rd)
  );

  // sof pixels see a freshly cleared frame context, so substitute the cleared values here.
  always_comb begin
    accept    = pix_valid & pix_ready;
    eff_col   = pix_sof ? '0 : col;
    eff_first = pix_sof | first_row;
    eff_next  = pix_sof ? LBL_FIRST : next_label;
    lft       = (eff_col == '0) ? BG : left_lbl;
    up        = eff_first ? BG : buf_rd;
    is_new    = pix_bin && (lft == BG) && (up == BG);
    conflict  = pix_bin && (lft != BG) && (up != BG) && (lft != up);
    cur       = BG;
    if (pix_bin) begin
      if (is_new)          cur = eff_next;
      else if (lft == BG)  cur = up;
      else if (up == BG)   cur = lft;
      else if (lft < up)   cur = lft;
      else                 cur = up;
    end
    line_end  = pix_eol || (eff_col == COL_LAST);
    bad_end   = pix_eol != (eff_col == COL_LAST);
  end

  always_comb begin
    state_n = state;
    case (state)
      SCAN:    if (accept && conflict) state_n = UF_REQ;
      UF_REQ:  state_n = UF_WAIT;
      UF_WAIT: if (uf_done) state_n = SCAN;
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SCAN;
    else          state <= state_n;
  end

  assign uf_start  = (state == UF_REQ);
  assign label_cnt = next_label - 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_ready  <= 1'b0;
      lbl_valid  <= 1'b0;
      lbl_label  <= BG;
      lbl_eol    <= 1'b0;
      uf_op      <= UF_OP_FIND;
      uf_node1   <= BG;
      uf_node2   <= BG;
      lbl_ovf    <= 1'b0;
      line_err   <= 1'b0;
      next_label <= LBL_FIRST;
      col        <= '0;
      first_row  <= 1'b1;
      left_lbl   <= BG;
    end else begin
      pix_ready <= (state_n == SCAN);
      lbl_valid <= accept;
      if (accept) begin
        lbl_label <= cur;
        lbl_eol   <= pix_eol;
        left_lbl  <= cur;
        if (is_new) begin
          // Once the top label is handed out, further new components share it.
          next_label <= (eff_next == LBL_MAX) ? LBL_MAX : eff_next + 1'b1;
          lbl_ovf    <= (pix_sof ? 1'b0 : lbl_ovf) | (eff_next == LBL_MAX);
        end else begin
          next_label <= eff_next;
          lbl_ovf    <= pix_sof ? 1'b0 : lbl_ovf;
        end
        line_err <= (pix_sof ? 1'b0 : line_err) | bad_end;
        if (line_end) begin
          col       <= '0;
          first_row <= 1'b0;
        end else begin
          col       <= eff_col + 1'b1;
          first_row <= eff_first;
        end
        if (conflict) begin
          uf_op    <= UF_OP_UNION;
          uf_node1 <= lft;
          uf_node2 <= up;
        end
      end
    end
  end

endmodule
